sha_msg_schedule: RTL and testbench
===================================

// Module: sha_msg_schedule
// PURPOSE
//  Parametrised SHA-2 message-schedule generator: loads one 16-word block, then streams W[0..ROUNDS-1].
//  Sits between the block padder and the compression round core; one W word per round.
//  Holds a 16-word sliding window. Computes sigma0/sigma1 expansion for SHA-256 (32b) or SHA-512 (64b).
//  Has valid/ready handshakes on both sides and a per-block done pulse.
// PARAMETERS
//  WORD_W   32   word width; legal values 32 (SHA-256) or 64 (SHA-512)
//  ROUNDS   64   W words emitted per block; must be 64 when WORD_W=32, 80 when WORD_W=64
//  IDX_W    7    width of out_idx; must be >= $clog2(ROUNDS)
// PORTS
//  clk        in   1        single clock, all logic on posedge
//  rst        in   1        synchronous, active-low reset
//  in_valid   in   1        in_word is valid
//  in_ready   out  1        block accepts an input word (LOAD state only)
//  in_word    in   WORD_W   message word; words arrive in order W[0]..W[15]
//  out_valid  out  1        out_word/out_idx valid (GEN state only)
//  out_ready  in   1        downstream round core takes the word
//  out_word   out  WORD_W   W[t]
//  out_idx    out  IDX_W    t, 0..ROUNDS-1
//  done       out  1        one-cycle pulse, the cycle after W[ROUNDS-1] is accepted
// BEHAVIOUR
//  Reset (rst==0 at posedge): state=LOAD, load count=0, t=0, in_ready=1, out_valid=0, done=0.
//   out_word=0, out_idx=0, window cleared. Reset mid-block discards the block with no done pulse.
//  LOAD: in_ready=1, out_valid=0. When in_valid&&in_ready: win[cnt]<=in_word, cnt++.
//   On the 16th accept (cnt==15): go to GEN next cycle with t=0; in_ready drops in that same cycle.
//  GEN: in_ready=0, out_valid=1, out_word=win[0], out_idx=t. Output is registered and stable while stalled.
//   On out_valid&&out_ready:
//    - win[i]<=win[i+1] for i=0..14.
//    - win[15]<=sigma1(win[14])+win[9]+sigma0(win[1])+win[0], mod 2^WORD_W. Carries are discarded.
//    - t++.
//   Result: W[t]=input word for t<16; W[t]=s1(W[t-2])+W[t-7]+s0(W[t-15])+W[t-16] for t>=16.
//   Throughput is one W per cycle while out_ready=1. Latency from the 16th input accept to the first out_valid is 1 cycle.
//   On the accept of t==ROUNDS-1: next cycle done=1, state=LOAD, cnt=0, in_ready=1.
//   A new block can then load straight away; there is no bubble beyond the done cycle.
//  The 64-bit sums are WORD_W wide. ROTR(x,n) = (x>>n)|(x<<(WORD_W-n)); SHR is a logical shift.
//  WORD_W=32: sigma0 = ROTR7^ROTR18^SHR3;  sigma1 = ROTR17^ROTR19^SHR10.
//  WORD_W=64: sigma0 = ROTR1^ROTR8^SHR7;   sigma1 = ROTR19^ROTR61^SHR6.
//  Stalls: out_ready=0 holds the window, t and out_word unchanged, for any number of cycles.
//   in_valid=0 in LOAD holds cnt.
//  in_valid is ignored in GEN; no word is consumed. out_ready is ignored in LOAD.
//  Illegal parameter combinations fail elaboration via a generate-time $error.
// STRUCTURE
//  Shared package sha2_pkg holds:
//   - the rotation/shift constant tables indexed by WORD_W;
//   - the sigma0/sigma1 functions;
//   - the state encoding localparams LOAD=1'b0 and GEN=1'b1.
//  One sub-module: sha_sigma (combinational, params WORD_W and SEL 0/1) for the small sigma.
//   It is instantiated twice and reused later by the round core's big-Sigma variant.
//  Top module: FSM, load counter (4b), round counter (IDX_W), 16xWORD_W window, and the adder tree.
// TESTING
//  1 "abc" block, WORD_W=32: W0=0x61626380, W1..14=0, W15=0x00000018 with out_ready=1.
//    -> W16=0x61626380, W17=0x000F0000; W[0..63] match the golden model; done pulses once after idx 63.
//  2 Random stalls: toggle out_ready 50% on scenario 1 -> identical W sequence.
//    out_word/out_idx are stable across every stall; the total accepted count is 64.
//  3 Input gaps: in_valid pulses every 3rd cycle -> load takes 46 cycles.
//    First out_valid is 1 cycle after the 16th accept; the output matches scenario 1.
//  4 Reset mid-GEN: assert rst=0 at t=20 -> next cycle in_ready=1, out_valid=0, no done pulse.
//    A fresh "abc" load then reproduces scenario 1 exactly.
//  5 Back-to-back blocks: a second block is offered on the done cycle.
//    -> accepted immediately; both W streams are correct; 2 done pulses.
//  6 WORD_W=64, ROUNDS=80, SHA-512 "abc" block: W0=0x6162638000000000, W15=0x18.
//    -> all 80 words match the golden model; out_idx wraps 79 -> next block at 0.

Source files
------------

// File: rtl/sha2_pkg.sv
// Shared SHA-2 definitions: small-sigma rotate/shift amounts, sigma functions
// and the message-schedule state encoding.
package sha2_pkg;

    typedef enum logic {
        LOAD = 1'b0,
        GEN  = 1'b1
    } state_t;

    // Two rotate amounts and one logical right shift for each small sigma
    typedef struct packed {
        int unsigned rot_a;
        int unsigned rot_b;
        int unsigned shr;
    } sig_amt_t;

    localparam sig_amt_t SIG32_0 = '{rot_a: 7,  rot_b: 18, shr: 3};
    localparam sig_amt_t SIG32_1 = '{rot_a: 17, rot_b: 19, shr: 10};
    localparam sig_amt_t SIG64_0 = '{rot_a: 1,  rot_b: 8,  shr: 7};
    localparam sig_amt_t SIG64_1 = '{rot_a: 19, rot_b: 61, shr: 6};

    function automatic sig_amt_t sig_amt(input int word_w, input int sel);
        if (word_w == 64) begin
            return (sel != 0) ? SIG64_1 : SIG64_0;
        end
        return (sel != 0) ? SIG32_1 : SIG32_0;
    endfunction

    function automatic logic [31:0] rotr32(input logic [31:0] x, input int unsigned n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [63:0] rotr64(input logic [63:0] x, input int unsigned n);
        return (x >> n) | (x << (64 - n));
    endfunction

    function automatic logic [31:0] sigma32(input logic [31:0] x, input int sel);
        sig_amt_t a;
        a = sig_amt(32, sel);
        return rotr32(x, a.rot_a) ^ rotr32(x, a.rot_b) ^ (x >> a.shr);
    endfunction

    function automatic logic [63:0] sigma64(input logic [63:0] x, input int sel);
        sig_amt_t a;
        a = sig_amt(64, sel);
        return rotr64(x, a.rot_a) ^ rotr64(x, a.rot_b) ^ (x >> a.shr);
    endfunction

    function automatic logic [31:0] sigma0_32(input logic [31:0] x);
        return sigma32(x, 0);
    endfunction

    function automatic logic [31:0] sigma1_32(input logic [31:0] x);
        return sigma32(x, 1);
    endfunction

    function automatic logic [63:0] sigma0_64(input logic [63:0] x);
        return sigma64(x, 0);
    endfunction

    function automatic logic [63:0] sigma1_64(input logic [63:0] x);
        return sigma64(x, 1);
    endfunction

endpackage

// File: rtl/sha_sigma.sv
// Combinational SHA-2 small sigma: SEL=0 gives sigma0, SEL=1 gives sigma1,
// for 32-bit (SHA-256) or 64-bit (SHA-512) words.
module sha_sigma
    import sha2_pkg::*;
#(
    parameter int WORD_W = 32,
    parameter int SEL    = 0
) (
    input  logic [WORD_W-1:0] x,
    output logic [WORD_W-1:0] y
);

    generate
        if (WORD_W == 64) begin : g_w64
            assign y = (SEL != 0) ? sigma1_64(x) : sigma0_64(x);
        end else begin : g_w32
            assign y = (SEL != 0) ? sigma1_32(x) : sigma0_32(x);
        end
    endgenerate

endmodule

// File: rtl/sha_msg_schedule.sv
// SHA-2 message schedule: loads a 16-word block, then streams W[0..ROUNDS-1]
// from a sliding 16-word window with valid/ready on both sides.
module sha_msg_schedule
    import sha2_pkg::*;
#(
    parameter int WORD_W = 32,
    parameter int ROUNDS = 64,
    parameter int IDX_W  = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_word,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] out_word,
    output logic [IDX_W-1:0]  out_idx,
    output logic              done
);

    localparam int               WIN      = 16;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROUNDS - 1);

    generate
        if (!((WORD_W == 32 && ROUNDS == 64) || (WORD_W == 64 && ROUNDS == 80))
            || (IDX_W < $clog2(ROUNDS))) begin : g_bad_params
            $error("sha_msg_schedule: illegal WORD_W/ROUNDS/IDX_W combination");
        end
    endgenerate

    state_t            state;
    state_t            state_nxt;
    logic [3:0]        cnt;
    logic [IDX_W-1:0]  t;
    logic [WORD_W-1:0] win [WIN];
    logic [WORD_W-1:0] s0;
    logic [WORD_W-1:0] s1;
    logic [WORD_W-1:0] w_new;
    logic              in_fire;
    logic              out_fire;
    logic              load_last;
    logic              gen_last;

    sha_sigma #(.WORD_W(WORD_W), .SEL(0)) u_sigma0 (.x(win[1]),  .y(s0));
    sha_sigma #(.WORD_W(WORD_W), .SEL(1)) u_sigma1 (.x(win[14]), .y(s1));

    // Window slot 0 is W[t]; the new slot 15 is W[t+16], carries dropped
    assign w_new = s1 + win[9] + s0 + win[0];

    assign in_ready  = (state == LOAD);
    assign out_valid = (state == GEN);
    assign out_word  = win[0];
    assign out_idx   = t;

    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;
    assign load_last = in_fire && (cnt == 4'd15);
    assign gen_last  = out_fire && (t == LAST_IDX);

    always_comb begin
        // NOTE: default first so every path assigns state_nxt and no latch is inferred.
        state_nxt = state;
        case (state)
            LOAD:    if (load_last) state_nxt = GEN;
            GEN:     if (gen_last)  state_nxt = LOAD;
            default: state_nxt = LOAD;
        endcase
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= LOAD;
            cnt   <= '0;
            t     <= '0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            done  <= gen_last;
            if (in_fire) begin
                cnt <= cnt + 4'd1;
            end
            if (gen_last) begin
                t <= '0;
            end else if (out_fire) begin
                t <= t + IDX_W'(1);
            end
        end
    end

    // NOTE: the window is cleared on reset so out_word reads 0 straight out of reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < WIN; i++) begin
                win[i] <= '0;
            end
        end else if (in_fire) begin
            win[cnt] <= in_word;
        end else if (out_fire) begin
            for (int i = 0; i < WIN - 1; i++) begin
                win[i] <= win[i+1];
            end
            win[WIN-1] <= w_new;
        end
    end

endmodule

// File: tb/tb_sha_msg_schedule.sv
// Scoreboard bench for sha_msg_schedule: SHA-256 and SHA-512 instances checked
// against a recurrence-level model of the message schedule.
module tb_sha_msg_schedule;

    typedef logic [63:0] blk_t [16];
    typedef struct {
        logic [63:0] word;
        int          idx;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid  [2];
    logic        in_ready  [2];
    logic        out_valid [2];
    logic        out_ready [2];
    logic        done      [2];
    logic [6:0]  out_idx   [2];
    logic [31:0] in_word32;
    logic [63:0] in_word64;
    logic [31:0] ow32;
    logic [63:0] ow64;

    exp_t q32[$];
    exp_t q64[$];
    int   total = 0;
    int   bad   = 0;
    int   accepts  [2];
    int   done_cnt [2];
    bit   exp_done [2];
    bit   stall_mode = 1'b0;

    exp_t        mon_e;
    logic [63:0] mon_w;
    bit          mon_have;

    sha_msg_schedule #(.WORD_W(32), .ROUNDS(64), .IDX_W(7)) dut32 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_word(in_word32),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .out_word(ow32), .out_idx(out_idx[0]), .done(done[0])
    );

    sha_msg_schedule #(.WORD_W(64), .ROUNDS(80), .IDX_W(7)) dut64 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_word(in_word64),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .out_word(ow64), .out_idx(out_idx[1]), .done(done[1])
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model: W[t] from the SHA-2 recurrence ----------------
    function automatic logic [63:0] wmask(input int w);
        return (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    endfunction

    function automatic logic [63:0] rotr(input logic [63:0] x, input int n, input int w);
        return ((x >> n) | (x << (w - n))) & wmask(w);
    endfunction

    function automatic logic [63:0] ref_s0(input logic [63:0] x, input int w);
        if (w == 64) return rotr(x, 1, 64) ^ rotr(x, 8, 64) ^ (x >> 7);
        return rotr(x, 7, 32) ^ rotr(x, 18, 32) ^ (x >> 3);
    endfunction

    function automatic logic [63:0] ref_s1(input logic [63:0] x, input int w);
        if (w == 64) return rotr(x, 19, 64) ^ rotr(x, 61, 64) ^ (x >> 6);
        return rotr(x, 17, 32) ^ rotr(x, 19, 32) ^ (x >> 10);
    endfunction

    task automatic push_expected(input int d, input blk_t b);
        logic [63:0] w [80];
        int          wd;
        int          r;
        wd = (d != 0) ? 64 : 32;
        r  = (d != 0) ? 80 : 64;
        for (int t = 0; t < 16; t++) w[t] = b[t] & wmask(wd);
        for (int t = 16; t < r; t++)
            w[t] = (ref_s1(w[t-2], wd) + w[t-7] + ref_s0(w[t-15], wd) + w[t-16]) & wmask(wd);
        for (int t = 0; t < r; t++) begin
            exp_t e;
            e.word = w[t];
            e.idx  = t;
            if (d != 0) q64.push_back(e);
            else        q32.push_back(e);
        end
    endtask

    // ---------------- monitor: compares every presented word against the queue head ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                for (int d = 0; d < 2; d++) begin
                    mon_w = (d != 0) ? ow64 : {32'b0, ow32};
                    if (exp_done[d] || done[d]) begin
                        check($sformatf("done dut%0d", d), 64'(done[d]), 64'(exp_done[d]));
                        if (done[d]) begin
                            done_cnt[d]++;
                            check($sformatf("in_ready on done dut%0d", d), 64'(in_ready[d]), 64'd1);
                        end
                        exp_done[d] = 1'b0;
                    end
                    if (out_valid[d]) begin
                        mon_have = (d != 0) ? (q64.size() > 0) : (q32.size() > 0);
                        if (!mon_have) begin
                            total++;
                            bad++;
                            $display("FAIL unexpected output dut%0d: idx=%0d word=%h", d, out_idx[d], mon_w);
                        end else begin
                            if (d != 0) mon_e = q64[0];
                            else        mon_e = q32[0];
                            check($sformatf("word dut%0d idx%0d", d, mon_e.idx), mon_w, mon_e.word);
                            check($sformatf("idx dut%0d", d), 64'(out_idx[d]), 64'(mon_e.idx));
                            if (out_ready[d]) begin
                                if (d != 0) void'(q64.pop_front());
                                else        void'(q32.pop_front());
                                accepts[d]++;
                                if (mon_e.idx == ((d != 0) ? 79 : 63)) exp_done[d] = 1'b1;
                            end
                        end
                    end
                end
            end
        end
    end

    // out_ready driver: always ready, or a fair coin per cycle while stalling
    initial begin
        forever begin
            @(posedge clk);
            #1;
            for (int d = 0; d < 2; d++)
                out_ready[d] = stall_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // ---------------- stimulus ----------------
    task automatic load_block(input int d, input blk_t b, input int gap, input int exp_cycles);
        int cycles;
        int n;
        bit acc;
        cycles = 0;
        push_expected(d, b);
        for (int k = 0; k < 16; k++) begin
            if (k > 0) begin
                repeat (gap) begin
                    in_valid[d] = 1'b0;
                    @(posedge clk);
                    #1;
                    cycles++;
                end
            end
            in_valid[d] = 1'b1;
            if (d != 0) in_word64 = b[k];
            else        in_word32 = b[k][31:0];
            n   = 0;
            acc = 1'b0;
            while (!acc && n < 2000) begin
                @(negedge clk);
                acc = in_ready[d];
                @(posedge clk);
                #1;
                cycles++;
                n++;
            end
            if (!acc) begin
                total++;
                bad++;
                $display("FAIL load timeout dut%0d word %0d", d, k);
                in_valid[d] = 1'b0;
                return;
            end
        end
        in_valid[d] = 1'b0;
        check($sformatf("in_ready after load dut%0d", d), 64'(in_ready[d]), 64'd0);
        check($sformatf("out_valid after load dut%0d", d), 64'(out_valid[d]), 64'd1);
        if (exp_cycles > 0) check("load cycles", 64'(cycles), 64'(exp_cycles));
    endtask

    task automatic wait_drain(input int d);
        int n;
        n = 0;
        while ((((d != 0) ? q64.size() : q32.size()) != 0 || exp_done[d]) && n < 5000) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 5000) begin
            total++;
            bad++;
            $display("FAIL drain timeout dut%0d: %0d words outstanding", d,
                     (d != 0) ? q64.size() : q32.size());
        end
    endtask

    task automatic rand_block(input int d, output blk_t b);
        for (int k = 0; k < 16; k++)
            b[k] = {$urandom, $urandom} & wmask((d != 0) ? 64 : 32);
    endtask

    initial begin
        blk_t abc32;
        blk_t abc512;
        blk_t ra;
        blk_t rb;
        int   a0;
        int   dc;
        int   n;

        for (int k = 0; k < 16; k++) begin
            abc32[k]  = 64'd0;
            abc512[k] = 64'd0;
        end
        abc32[0]   = 64'h0000_0000_6162_6380;
        abc32[15]  = 64'h18;
        abc512[0]  = 64'h6162_6380_0000_0000;
        abc512[15] = 64'h18;

        for (int d = 0; d < 2; d++) begin
            in_valid[d]  = 1'b0;
            out_ready[d] = 1'b1;
            accepts[d]   = 0;
            done_cnt[d]  = 0;
            exp_done[d]  = 1'b0;
        end
        in_word32 = '0;
        in_word64 = '0;

        // Reset state
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset in_ready32", 64'(in_ready[0]), 64'd1);
        check("reset out_valid32", 64'(out_valid[0]), 64'd0);
        check("reset out_word32", 64'(ow32), 64'd0);
        check("reset out_idx32", 64'(out_idx[0]), 64'd0);
        check("reset done32", 64'(done[0]), 64'd0);
        check("reset in_ready64", 64'(in_ready[1]), 64'd1);
        check("reset out_valid64", 64'(out_valid[1]), 64'd0);
        check("reset out_word64", ow64, 64'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // 1: "abc" block, always ready
        a0 = accepts[0];
        load_block(0, abc32, 0, 16);
        wait_drain(0);
        check("s1 accepted count", 64'(accepts[0] - a0), 64'd64);

        // 2: random output stalls
        stall_mode = 1'b1;
        a0 = accepts[0];
        load_block(0, abc32, 0, 0);
        wait_drain(0);
        check("s2 accepted count", 64'(accepts[0] - a0), 64'd64);
        stall_mode = 1'b0;

        // 3: in_valid every third cycle
        load_block(0, abc32, 2, 46);
        wait_drain(0);

        // 4: reset at t=20, then a fresh block
        dc = done_cnt[0];
        load_block(0, abc32, 0, 16);
        n = 0;
        while (!(out_valid[0] && out_idx[0] == 7'd20) && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("s4 reached t=20", 64'(out_idx[0]), 64'd20);
        rst = 1'b0;
        q32.delete();
        @(posedge clk);
        #1;
        check("s4 in_ready after reset", 64'(in_ready[0]), 64'd1);
        check("s4 out_valid after reset", 64'(out_valid[0]), 64'd0);
        check("s4 done after reset", 64'(done[0]), 64'd0);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("s4 no done pulse", 64'(done_cnt[0] - dc), 64'd0);
        load_block(0, abc32, 0, 16);
        wait_drain(0);

        // 5: back-to-back random blocks; the second is held on in_valid through GEN
        stall_mode = 1'b1;
        dc = done_cnt[0];
        rand_block(0, ra);
        rand_block(0, rb);
        load_block(0, ra, 0, 0);
        load_block(0, rb, 0, 0);
        wait_drain(0);
        check("s5 done pulses", 64'(done_cnt[0] - dc), 64'd2);
        stall_mode = 1'b0;

        // 6: SHA-512 "abc" then a random block straight after (idx wraps 79 -> 0)
        load_block(1, abc512, 0, 16);
        rand_block(1, rb);
        load_block(1, rb, 0, 0);
        wait_drain(1);

        repeat (2) @(posedge clk);
        #1;
        check("total done32", 64'(done_cnt[0]), 64'd6);
        check("total done64", 64'(done_cnt[1]), 64'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
